// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared lamp encodings, fault codes and monitor state type
package tlc_pkg;

    // Lamp encoding, one-hot: bit2 = red, bit1 = yellow, bit0 = green
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Fault codes; a lower value has higher priority
    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_INVALID      = 3'd1;
    localparam logic [2:0] FC_CONFLICT     = 3'd2;
    localparam logic [2:0] FC_SKIP_YELLOW  = 3'd3;
    localparam logic [2:0] FC_SHORT_YELLOW = 3'd4;
    localparam logic [2:0] FC_BAD_SEQ      = 3'd5;

    typedef enum logic [1:0] {
        START   = 2'd0,
        MONITOR = 2'd1,
        FLASH   = 2'd2
    } mon_state_e;

    // Width of a counter holding values 0..n-1, never less than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tlc_road_checker.sv
// rtl/tlc_road_checker.sv - per-road sample stage, yellow counter and sequence checks
//
// Ports:
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   lamp_i[2:0]     : controller lamp for this road
//   sample_o[2:0]   : registered sample of lamp_i
//   invalid_o       : sample is not a legal one-hot lamp
//   skip_o          : green went straight to red
//   short_o         : yellow went to red before MIN_YELLOW cycles of yellow
//   bad_seq_o       : yellow went to green, or red went to yellow
module tlc_road_checker
    import tlc_pkg::*;
#(
    parameter int MIN_YELLOW = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] lamp_i,
    output logic [2:0] sample_o,
    output logic       invalid_o,
    output logic       skip_o,
    output logic       short_o,
    output logic       bad_seq_o
);

    localparam int            YW   = cnt_w(MIN_YELLOW + 1);
    localparam logic [YW-1:0] YSAT = YW'(MIN_YELLOW);

    logic [2:0]    sample_q;
    logic [2:0]    prev_q;
    logic [YW-1:0] ycnt_q;
    logic [YW-1:0] ycnt_d;

    // The counter is updated from the current sample, so while sample_q is the
    // first non-yellow value it holds the length of the yellow run in prev_q.
    always_comb begin
        ycnt_d = '0;
        if (sample_q == LAMP_YEL) begin
            ycnt_d = (ycnt_q == YSAT) ? ycnt_q : ycnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_q <= LAMP_RED;
            prev_q   <= LAMP_RED;
            ycnt_q   <= '0;
        end else begin
            sample_q <= lamp_i;
            prev_q   <= sample_q;
            ycnt_q   <= ycnt_d;
        end
    end

    assign sample_o  = sample_q;
    assign invalid_o = !((sample_q == LAMP_RED) || (sample_q == LAMP_YEL) ||
                         (sample_q == LAMP_GRN));
    assign skip_o    = (prev_q == LAMP_GRN) && (sample_q == LAMP_RED);
    assign short_o   = (prev_q == LAMP_YEL) && (sample_q == LAMP_RED) && (ycnt_q < YSAT);
    assign bad_seq_o = ((prev_q == LAMP_YEL) && (sample_q == LAMP_GRN)) ||
                       ((prev_q == LAMP_RED) && (sample_q == LAMP_YEL));

endmodule

// File: rtl/tlc_conflict_monitor.sv
// rtl/tlc_conflict_monitor.sv - safety monitor between traffic controller and road drivers
//
// Ports:
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   clear                   : fault clear request (only with FAULT_CLEAR_EN defined)
//   north/south/east/west   : controller lamps, one-hot {red, yellow, green}
//   lamp_north/south/east/west : lamps to the road drivers
//   fault                   : latched fault flag
//   fault_code[2:0]         : code of the first fault detected
//
// Build option: FAULT_CLEAR_EN adds the clear input so FLASH can be left
// without a reset once all four roads are sampled red.
module tlc_conflict_monitor
    import tlc_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int FLASH_HALF = 5,
    parameter int STARTUP    = 4
) (
    input  logic       clock,
    input  logic       reset,
`ifdef FAULT_CLEAR_EN
    input  logic       clear,
`endif
    input  logic [2:0] north,
    input  logic [2:0] south,
    input  logic [2:0] east,
    input  logic [2:0] west,
    output logic [2:0] lamp_north,
    output logic [2:0] lamp_south,
    output logic [2:0] lamp_east,
    output logic [2:0] lamp_west,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int             STW     = cnt_w(STARTUP);
    localparam logic [STW-1:0] ST_LAST = STW'(STARTUP - 1);
    localparam int             FLW     = cnt_w(2 * FLASH_HALF);
    localparam logic [FLW-1:0] FL_LAST = FLW'(2 * FLASH_HALF - 1);
    localparam logic [FLW-1:0] FL_HALF = FLW'(FLASH_HALF);

    logic [2:0] road_in [4];
    logic [2:0] smp     [4];
    logic [2:0] lamp_v  [4];
    logic [3:0] inv_v, skip_v, short_v, bad_v;

    assign road_in[0] = north;
    assign road_in[1] = south;
    assign road_in[2] = east;
    assign road_in[3] = west;

    for (genvar g = 0; g < 4; g++) begin : g_road
        tlc_road_checker #(
            .MIN_YELLOW(MIN_YELLOW)
        ) u_road (
            .clock    (clock),
            .reset    (reset),
            .lamp_i   (road_in[g]),
            .sample_o (smp[g]),
            .invalid_o(inv_v[g]),
            .skip_o   (skip_v[g]),
            .short_o  (short_v[g]),
            .bad_seq_o(bad_v[g])
        );
    end

    // Conflict: more than one road showing anything other than red
    logic [2:0] n_active;
    always_comb begin
        n_active = '0;
        for (int i = 0; i < 4; i++) begin
            n_active = n_active + 3'(smp[i] != LAMP_RED);
        end
    end

    logic [2:0] det_code;
    always_comb begin
        det_code = FC_NONE;
        if (|inv_v)              det_code = FC_INVALID;
        else if (n_active > 3'd1) det_code = FC_CONFLICT;
        else if (|skip_v)        det_code = FC_SKIP_YELLOW;
        else if (|short_v)       det_code = FC_SHORT_YELLOW;
        else if (|bad_v)         det_code = FC_BAD_SEQ;
    end

`ifdef FAULT_CLEAR_EN
    logic all_red;
    assign all_red = (smp[0] == LAMP_RED) && (smp[1] == LAMP_RED) &&
                     (smp[2] == LAMP_RED) && (smp[3] == LAMP_RED);
`endif

    mon_state_e     state_q, state_d;
    logic [STW-1:0] st_cnt_q, st_cnt_d;
    logic [FLW-1:0] fl_cnt_q, fl_cnt_d;
    logic           fault_q, fault_d;
    logic [2:0]     code_q, code_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= START;
            st_cnt_q <= '0;
            fl_cnt_q <= '0;
            fault_q  <= 1'b0;
            code_q   <= FC_NONE;
        end else begin
            state_q  <= state_d;
            st_cnt_q <= st_cnt_d;
            fl_cnt_q <= fl_cnt_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        st_cnt_d = st_cnt_q;
        fl_cnt_d = '0;
        fault_d  = fault_q;
        code_d   = code_q;
        case (state_q)
            START: begin
                if (st_cnt_q == ST_LAST) begin
                    state_d  = MONITOR;
                    st_cnt_d = '0;
                end else begin
                    st_cnt_d = st_cnt_q + 1'b1;
                end
            end
            MONITOR: begin
                if (det_code != FC_NONE) begin
                    state_d = FLASH;
                    fault_d = 1'b1;
                    code_d  = det_code;
                end
            end
            FLASH: begin
                fl_cnt_d = (fl_cnt_q == FL_LAST) ? '0 : fl_cnt_q + 1'b1;
`ifdef FAULT_CLEAR_EN
                if (clear && all_red) begin
                    state_d  = START;
                    st_cnt_d = '0;
                    fl_cnt_d = '0;
                    fault_d  = 1'b0;
                    code_d   = FC_NONE;
                end
`endif
            end
            default: state_d = START;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lamp_v[i] = LAMP_RED;
            if (state_q == MONITOR) begin
                lamp_v[i] = smp[i];
            end else if (state_q == FLASH) begin
                lamp_v[i] = (fl_cnt_q < FL_HALF) ? LAMP_RED : LAMP_OFF;
            end
        end
    end

    assign lamp_north = lamp_v[0];
    assign lamp_south = lamp_v[1];
    assign lamp_east  = lamp_v[2];
    assign lamp_west  = lamp_v[3];
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: doc/tlc_conflict_monitor.md
Name: tlc_conflict_monitor

Overview:
Safety stage directly downstream of the 4-way traffic controller.
- Consumes the controller's four 3-bit road outputs.
- Checks every cycle for illegal lamp states and illegal sequencing, and forwards the lamps to the road drivers.
- On any violation, latches a fault and overrides all four roads with flashing red until cleared.

Parameters:
- MIN_YELLOW, default 3: minimum consecutive cycles a road must show yellow before it goes red.
- FLASH_HALF, default 5: cycles per half-period of the fault flash.
- STARTUP, default 4: cycles of forced all-red after reset; checks are disabled during this window.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- north, input, 3: controller lamp for north road. Encoding is one-hot: bit2 = red, bit1 = yellow, bit0 = green.
- south, input, 3: same encoding as north.
- east, input, 3: same encoding as north.
- west, input, 3: same encoding as north.
- lamp_north, output, 3: driven lamp for north road, same encoding.
- lamp_south, output, 3: driven lamp for south road, same encoding.
- lamp_east, output, 3: driven lamp for east road, same encoding.
- lamp_west, output, 3: driven lamp for west road, same encoding.
- fault, output, 1: latched fault flag.
- fault_code, output, 3: latched code of the first fault detected.

Behaviour:
Clocking and reset
- Single clock domain; reset is asynchronous and active-high.
- Reset values: all lamp_* = 3'b100, fault = 0, fault_code = 0, FSM in START, counters cleared.
- Reset asserted mid-operation, including in FLASH, returns to this state immediately.

Sampling and latency
- Inputs are registered once (sample stage); all checks use the sampled values and the previous sample.
- In MONITOR, lamp_* = sampled input, giving 1 cycle latency.

Per-road tracking
- Each road has a yellow counter: increments while the sample is 3'b010, saturates at MIN_YELLOW, clears on any other value.
- Counters also run during START.

Checks (MONITOR only)
1. INVALID: any road sample not in {100, 010, 001}.
2. CONFLICT: more than one road non-red in the same sample.
3. SKIP_YELLOW: a road goes 001 -> 100.
4. SHORT_YELLOW: a road goes 010 -> 100 with yellow counter < MIN_YELLOW.
5. BAD_SEQ: a road goes 010 -> 001 or 100 -> 010.
- Legal transitions: hold; 100 -> 001; 001 -> 010; 010 -> 100 after at least MIN_YELLOW cycles of yellow.
- When several checks fire in the same cycle, the lowest code wins, and only the first fault is latched.

FSM
- START: lamps forced 100; lasts STARTUP cycles, then goes to MONITOR. No checks run.
- MONITOR: lamps pass through. A detected fault sets fault = 1 and fault_code, and moves to FLASH on the same clock edge.
- FLASH: all lamps 100 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, repeating, starting with the on phase on the first FLASH cycle.
  - The flash counter wraps at 2*FLASH_HALF - 1.
  - fault and fault_code hold; inputs are ignored.
  - Exit is by reset only, unless the optional feature is compiled in.

Widths
- Counter widths are derived with $clog2, minimum 1 bit.

Optional Feature:
FAULT_CLEAR_EN
- Defined:
  - Adds input port clear (1 bit).
  - In FLASH, if clear = 1 and all four sampled inputs = 100 in the same cycle, go to START, clear fault and fault_code, and restart the startup count.
  - clear has no effect in START or MONITOR.
- Undefined:
  - No clear port; FLASH is left only by reset.

Decomposition:
- Package tlc_pkg:
  - Lamp constants LAMP_RED = 3'b100, LAMP_YEL = 3'b010, LAMP_GRN = 3'b001, LAMP_OFF = 3'b000.
  - Fault codes: FC_NONE = 0, FC_INVALID = 1, FC_CONFLICT = 2, FC_SKIP_YELLOW = 3, FC_SHORT_YELLOW = 4, FC_BAD_SEQ = 5.
  - Monitor state enum {START, MONITOR, FLASH}.
- Sub-module tlc_road_checker, instantiated 4 times:
  - Contains the sample and previous registers, the yellow counter, and the invalid/skip/short/bad-sequence flags for one road.
  - The top level does the conflict check, priority selection, FSM and output mux.

Test Plan:
- Reset, then any inputs for STARTUP = 4 cycles -> lamps 100, fault = 0; MONITOR entered on cycle 5; no fault even if inputs are illegal during START.
- Legal cycle: north 100 -> 001 -> 010 for 3 cycles -> 100, others held 100 -> lamps follow inputs with 1-cycle latency, fault = 0 throughout.
- north = 001 and east = 001 in the same cycle -> fault = 1, fault_code = 2 one edge later; lamps then flash 100 x5 / 000 x5 repeating.
- north 010 for 2 cycles then 100 -> fault_code = 4. Separately, south 001 -> 100 -> fault_code = 3.
- west = 011 together with a conflict in the same cycle -> fault_code = 1 (priority). A later illegal input does not change the latched code.
- FAULT_CLEAR_EN defined: in FLASH, clear = 1 with all inputs 100 -> START, fault = 0; clear = 1 with north = 001 -> stays in FLASH. Async reset asserted mid-flash -> lamps 100 immediately.
